key_scan_sched: RTL and testbench

Shared-engine debounce scheduler for up to NKEY active-low key inputs. A single programmable sample tick and a single counter-update datapath are time-multiplexed round-robin across all keys, replacing one per-key debounce instance with prescaler chain. Debounced edges are queued as events in a small FIFO that the CPU reads over the wishbone slave bus. An optional interrupt signals pending events.

---
 rtl/key_scan_sched_if.sv | 22 ++
 rtl/key_scan_sched.sv | 168 ++++++++++++++++
 tb/tb_key_scan_sched.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/key_scan_sched_if.sv
// Wishbone-style register bus for key_scan_sched.
// The master drives strobe/address/data and the slave returns a registered ack and read data.
interface key_scan_sched_if #(
  parameter int DSIZE = 8
);
  logic [1:0]       i_wb_adr;
  logic             i_wb_stb;
  logic             i_wb_we;
  logic [DSIZE-1:0] i_wb_dat;
  logic             o_wb_ack;
  logic [DSIZE-1:0] o_wb_dat;

  modport master (
    output i_wb_adr, i_wb_stb, i_wb_we, i_wb_dat,
    input  o_wb_ack, o_wb_dat
  );

  modport slave (
    input  i_wb_adr, i_wb_stb, i_wb_we, i_wb_dat,
    output o_wb_ack, o_wb_dat
  );
endinterface

// File: rtl/key_scan_sched.sv
// Round-robin shared debounce engine with an event FIFO behind a small register bus.
// Optional interrupt output: define KEYSCHED_IRQ_EN.
module key_scan_sched #(
  parameter int NKEY   = 4,
  parameter int DSIZE  = 8,
  parameter int STABLE = 100,
  parameter int FDEPTH = 4
) (
  input  logic            i_clk,
  input  logic            i_rst,
  key_scan_sched_if.slave wb,
  input  logic [NKEY-1:0] i_key_n,
  output logic [NKEY-1:0] o_key_n,
  output logic            o_irq
);
  localparam int IW = (NKEY > 1) ? $clog2(NKEY) : 1;
  localparam int AW = (FDEPTH > 1) ? $clog2(FDEPTH) : 1;

  typedef enum logic {IDLE, SCAN} state_t;

  logic [NKEY-1:0]  s1_q, s2_q, key_q;
  logic [6:0]       cnt_q [NKEY];
  logic [15:0]      p_q, pc_q, pc_d;
  logic [7:0]       lo_q;
  state_t           st_q;
  logic [IW-1:0]    idx_q;
  logic [7:0]       mem_q [FDEPTH];
  logic [AW-1:0]    wp_q, rp_q;
  logic [2:0]       fc_q, fc_d;
  logic             ovf_q, ovf_d, ack_q;
  logic [DSIZE-1:0] dat_q, rdat;
  logic             ien;

  logic tick, xfer, wr, rd, visit;
  logic lvl, cur, same, flip;
  logic empty, full, pop, push, do_push;
  logic [6:0] inc;
  logic [7:0] ev;

  function automatic logic [AW-1:0] nxt(input logic [AW-1:0] p);
    return (p == AW'(FDEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign tick  = (pc_q == p_q);
  assign xfer  = wb.i_wb_stb & ~ack_q;
  assign wr    = xfer & wb.i_wb_we;
  assign rd    = xfer & ~wb.i_wb_we;
  assign visit = (st_q == SCAN);

  assign lvl  = s2_q[idx_q];
  assign cur  = key_q[idx_q];
  assign inc  = cnt_q[idx_q] + 7'd1;
  assign same = (lvl == cur);
  assign flip = ~same & (inc == 7'(STABLE));
  assign ev   = {1'b1, lvl, 6'(idx_q)};

  assign empty   = (fc_q == 3'd0);
  assign full    = (fc_q == 3'(FDEPTH));
  assign pop     = rd & (wb.i_wb_adr == 2'd3) & ~empty;
  assign push    = visit & flip;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts
  assign do_push = push & (~full | pop);

  always_comb begin
    pc_d = tick ? 16'd0 : pc_q + 16'd1;
    if (wr && wb.i_wb_adr == 2'd1) pc_d = 16'd0;
    fc_d = fc_q;
    unique case ({do_push, pop})
      2'b10:   fc_d = fc_q + 3'd1;
      2'b01:   fc_d = fc_q - 3'd1;
      default: fc_d = fc_q;
    endcase
    ovf_d = ovf_q;
    if (wr && wb.i_wb_adr == 2'd2 && wb.i_wb_dat[4]) ovf_d = 1'b0;
    if (push && full && !pop) ovf_d = 1'b1;
  end

  always_comb begin
    rdat = '0;
    unique case (wb.i_wb_adr)
      2'd0: rdat = p_q[7:0];
      2'd1: rdat = p_q[15:8];
      2'd2: rdat = {fc_q, ovf_q, ien, visit, 2'b00};
      2'd3: rdat = empty ? 8'h00 : mem_q[rp_q];
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      st_q  <= IDLE;
      idx_q <= '0;
    end else begin
      unique case (st_q)
        IDLE: if (tick) begin
          st_q  <= SCAN;
          idx_q <= '0;
        end
        SCAN: if (idx_q == IW'(NKEY - 1)) st_q <= IDLE;
              else idx_q <= idx_q + 1'b1;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      s1_q  <= '1;
      s2_q  <= '1;
      key_q <= '1;
      for (int i = 0; i < NKEY; i++) cnt_q[i] <= '0;
      p_q   <= 16'd1999;
      lo_q  <= '0;
      pc_q  <= '0;
      wp_q  <= '0;
      rp_q  <= '0;
      fc_q  <= '0;
      ovf_q <= 1'b0;
      ack_q <= 1'b0;
      dat_q <= '0;
    end else begin
      s1_q  <= i_key_n;
      s2_q  <= s1_q;
      pc_q  <= pc_d;
      fc_q  <= fc_d;
      ovf_q <= ovf_d;
      ack_q <= xfer;
      dat_q <= rd ? rdat : '0;
      if (wr && wb.i_wb_adr == 2'd0) lo_q <= wb.i_wb_dat;
      if (wr && wb.i_wb_adr == 2'd1) p_q <= {wb.i_wb_dat, lo_q};
      if (visit) begin
        unique case (1'b1)
          same: cnt_q[idx_q] <= '0;
          flip: begin
            cnt_q[idx_q] <= '0;
            key_q[idx_q] <= lvl;
          end
          default: cnt_q[idx_q] <= inc;
        endcase
      end
      if (do_push) begin
        mem_q[wp_q] <= ev;
        wp_q        <= nxt(wp_q);
      end
      if (pop) rp_q <= nxt(rp_q);
    end
  end

`ifdef KEYSCHED_IRQ_EN
  logic ien_q, irq_q;
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      ien_q <= 1'b0;
      irq_q <= 1'b0;
    end else begin
      if (wr && wb.i_wb_adr == 2'd2) ien_q <= wb.i_wb_dat[3];
      irq_q <= ien_q & ~empty;
    end
  end
  assign ien   = ien_q;
  assign o_irq = irq_q;
`else
  assign ien   = 1'b0;
  assign o_irq = 1'b0;
`endif

  assign o_key_n     = key_q;
  assign wb.o_wb_ack = ack_q;
  assign wb.o_wb_dat = dat_q;
endmodule

// File: tb/tb_key_scan_sched.sv
// Directed bench for key_scan_sched: registers, debounce, FIFO overflow,
// simultaneous push/pop, interrupt and mid-scan reset.
module tb_key_scan_sched;
`ifdef KEYSCHED_IRQ_EN
  localparam logic EXP_IRQ = 1'b1;
`else
  localparam logic EXP_IRQ = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] key_i;
  logic [3:0] key_o;
  logic       irq;
  logic       irq_ack;
  logic [7:0] rd;
  int         total = 0;
  int         bad = 0;
  int         n;

  key_scan_sched_if #(.DSIZE(8)) bus();

  key_scan_sched #(
    .NKEY(4), .DSIZE(8), .STABLE(100), .FDEPTH(4)
  ) dut (
    .i_clk(clk), .i_rst(rst), .wb(bus),
    .i_key_n(key_i), .o_key_n(key_o), .o_irq(irq)
  );

  always #50 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic cyc(input int c);
    repeat (c) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic xfer(input logic [1:0] a, input logic we,
                      input logic [7:0] d, output logic [7:0] q);
    bus.i_wb_adr = a;
    bus.i_wb_we  = we;
    bus.i_wb_dat = d;
    bus.i_wb_stb = 1'b1;
    cyc(1);
    chk("ack", bus.o_wb_ack, 1);
    q       = bus.o_wb_dat;
    irq_ack = irq;
    bus.i_wb_stb = 1'b0;
    cyc(1);
    chk("ack_drop", {bus.o_wb_ack, bus.o_wb_dat}, 0);
  endtask

  task automatic wr(input logic [1:0] a, input logic [7:0] d);
    logic [7:0] q;
    xfer(a, 1'b1, d, q);
  endtask

  task automatic rdc(input string tag, input logic [1:0] a,
                     input logic [7:0] exp, input logic [7:0] m);
    logic [7:0] q;
    xfer(a, 1'b0, 8'h00, q);
    chk(tag, q & m, exp);
  endtask

  task automatic wait_key(input int k, input logic lv, output int c);
    c = 0;
    while (key_o[k] !== lv && c < 1500) begin
      cyc(1);
      c++;
    end
    chk("key_edge", key_o[k], lv);
  endtask

  task automatic edge_key(input int k, input logic lv);
    int c;
    key_i[k] = lv;
    wait_key(k, lv, c);
  endtask

  initial begin
    #4000000;
    $display("FAIL watchdog total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    key_i = 4'hF;
    bus.i_wb_adr = 2'd0;
    bus.i_wb_stb = 1'b0;
    bus.i_wb_we  = 1'b0;
    bus.i_wb_dat = 8'h00;
    cyc(3);
    chk("rst_out", {key_o, bus.o_wb_ack, bus.o_wb_dat, irq}, {4'hF, 1'b0, 8'h00, 1'b0});
    rst = 1'b0;
    cyc(1);
    rdc("presc_lo_rst", 2'd0, 8'hCF, 8'hFF);
    rdc("presc_hi_rst", 2'd1, 8'h07, 8'hFF);
    rdc("status_rst", 2'd2, 8'h00, 8'hFF);
    chk("key_rst", key_o, 4'hF);

    wr(2'd0, 8'd9);
    wr(2'd1, 8'd0);
    rdc("presc_lo", 2'd0, 8'h09, 8'hFF);
    rdc("presc_hi", 2'd1, 8'h00, 8'hFF);
    key_i[2] = 1'b0;
    wait_key(2, 1'b0, n);
    chk("key2_fall", key_o, 4'b1011);
    chk("key2_lat", (n >= 990 && n <= 1010), 1);
    rdc("status_one", 2'd2, 8'h20, 8'hFB);
    rdc("event_k2", 2'd3, 8'h82, 8'hFF);
    rdc("event_empty", 2'd3, 8'h00, 8'hFF);

    for (int i = 0; i < 4; i++) begin
      key_i[1] = 1'b0;
      cyc(490);
      key_i[1] = 1'b1;
      cyc(10);
    end
    chk("glitch_key", key_o, 4'b1011);
    rdc("glitch_fifo", 2'd2, 8'h00, 8'hFB);

    edge_key(2, 1'b1);
    edge_key(0, 1'b0);
    edge_key(1, 1'b0);
    edge_key(3, 1'b0);
    edge_key(0, 1'b1);
    chk("ovf_keys", key_o, 4'b0101);
    rdc("status_ovf", 2'd2, 8'h90, 8'hFB);
    wr(2'd2, 8'h10);
    rdc("status_clr", 2'd2, 8'h80, 8'hFB);
    rdc("ev0", 2'd3, 8'hC2, 8'hFF);
    rdc("ev1", 2'd3, 8'h80, 8'hFF);
    rdc("ev2", 2'd3, 8'h81, 8'hFF);
    rdc("ev3", 2'd3, 8'h83, 8'hFF);
    rdc("ev_empty", 2'd3, 8'h00, 8'hFF);

    edge_key(1, 1'b1);
    edge_key(3, 1'b1);
    edge_key(2, 1'b0);
    cyc(1);
    key_i[0] = 1'b0;
    key_i[3] = 1'b0;
    wait_key(0, 1'b0, n);
    cyc(2);
    xfer(2'd3, 1'b0, 8'h00, rd);
    chk("pp_pop", rd, 8'hC1);
    chk("pp_keys", key_o, 4'b0010);
    rdc("pp_status", 2'd2, 8'h80, 8'hFB);
    rdc("pp_ev0", 2'd3, 8'hC3, 8'hFF);
    rdc("pp_ev1", 2'd3, 8'h82, 8'hFF);
    rdc("pp_ev2", 2'd3, 8'h80, 8'hFF);
    rdc("pp_ev3", 2'd3, 8'h83, 8'hFF);
    rdc("pp_empty", 2'd3, 8'h00, 8'hFF);

    wr(2'd2, 8'h08);
    rdc("irq_en", 2'd2, {4'h0, EXP_IRQ, 3'b000}, 8'hFB);
    key_i[0] = 1'b1;
    wait_key(0, 1'b1, n);
    chk("irq_push", irq, 0);
    cyc(1);
    chk("irq_set", irq, EXP_IRQ);
    xfer(2'd3, 1'b0, 8'h00, rd);
    chk("irq_ev", rd, 8'hC0);
    chk("irq_at_ack", irq_ack, EXP_IRQ);
    chk("irq_clr", irq, 0);

    key_i[0] = 1'b0;
    wait_key(0, 1'b0, n);
    rst = 1'b1;
    bus.i_wb_adr = 2'd3;
    bus.i_wb_we  = 1'b0;
    bus.i_wb_stb = 1'b1;
    cyc(1);
    chk("mid_rst", {key_o, bus.o_wb_ack, bus.o_wb_dat, irq}, {4'hF, 1'b0, 8'h00, 1'b0});
    cyc(1);
    rst = 1'b0;
    bus.i_wb_stb = 1'b0;
    cyc(1);
    rdc("status_rst2", 2'd2, 8'h00, 8'hFF);
    rdc("presc_lo_rst2", 2'd0, 8'hCF, 8'hFF);
    rdc("presc_hi_rst2", 2'd1, 8'h07, 8'hFF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
